// File: rtl/pcie_ss_ctrl_pkg.sv
// Shared definitions for the PCIe subsystem control bridge.
// The PCIe CSR block imports the same command encoding from here.
package pcie_ss_ctrl_pkg;

    localparam int PCIE_LITE_CSR_WIDTH = 20;

    localparam logic [31:0] SS_ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        SS_CMD_IDLE = 2'b00,
        SS_CMD_RD   = 2'b01,
        SS_CMD_WR   = 2'b10,
        SS_CMD_RSVD = 2'b11
    } t_ss_cmd;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_DONE
    } t_ss_ctrl_state;

endpackage

// File: rtl/pcie_ss_ctrl_bridge.sv
// Level-coded SS_CMD to single Avalon-MM access bridge.
// Optional access timeout: define PCIE_SS_CTRL_TIMEOUT_EN.
module pcie_ss_ctrl_bridge
    import pcie_ss_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = PCIE_LITE_CSR_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_ss_ctrl_cmd,
    input  logic [ADDR_WIDTH-1:0] i_ss_ctrl_addr,
    input  logic [31:0]           i_ss_ctrl_writedata,
    output logic [31:0]           o_ss_readdata,
    output logic                  o_ss_ack,
    output logic                  o_ss_error,
    output logic [ADDR_WIDTH-1:0] o_avmm_address,
    output logic                  o_avmm_read,
    output logic                  o_avmm_write,
    output logic [31:0]           o_avmm_writedata,
    output logic [3:0]            o_avmm_byteenable,
    input  logic                  i_avmm_waitrequest,
    input  logic                  i_avmm_readdatavalid,
    input  logic [31:0]           i_avmm_readdata
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    t_ss_ctrl_state state_q, state_d;
    t_ss_cmd        cmd;
    logic           armed_q;
    logic           is_wr_q;
    logic           launch, rsvd, accept, rd_done, tmo, tmo_hit;

    assign cmd               = t_ss_cmd'(i_ss_ctrl_cmd);
    assign o_avmm_byteenable = 4'hF;

`ifdef PCIE_SS_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    // Fires on the last allowed cycle so the request drops right after it.
    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (launch) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_ISSUE || state_q == ST_WAIT_RD) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        rsvd    = 1'b0;
        accept  = 1'b0;
        rd_done = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (armed_q && (cmd == SS_CMD_RD || cmd == SS_CMD_WR)) begin
                    launch  = 1'b1;
                    state_d = ST_ISSUE;
                end else if (armed_q && cmd == SS_CMD_RSVD) begin
                    rsvd    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (!i_avmm_waitrequest) begin
                    accept  = 1'b1;
                    state_d = is_wr_q ? ST_DONE : ST_WAIT_RD;
                end else if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_RD: begin
                if (i_avmm_readdatavalid) begin
                    rd_done = 1'b1;
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cmd == SS_CMD_IDLE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            armed_q          <= 1'b1;
            is_wr_q          <= 1'b0;
            o_ss_readdata    <= '0;
            o_ss_ack         <= 1'b0;
            o_ss_error       <= 1'b0;
            o_avmm_address   <= '0;
            o_avmm_read      <= 1'b0;
            o_avmm_write     <= 1'b0;
            o_avmm_writedata <= '0;
        end else begin
            state_q <= state_d;
            // Re-arm only on an idle command so a held command fires once.
            if (cmd == SS_CMD_IDLE) begin
                armed_q <= 1'b1;
            end else if (launch || rsvd) begin
                armed_q <= 1'b0;
            end
            if (launch) begin
                o_avmm_address   <= i_ss_ctrl_addr;
                o_avmm_writedata <= i_ss_ctrl_writedata;
                is_wr_q          <= (cmd == SS_CMD_WR);
                o_avmm_read      <= (cmd == SS_CMD_RD);
                o_avmm_write     <= (cmd == SS_CMD_WR);
                o_ss_ack         <= 1'b0;
                o_ss_error       <= 1'b0;
                o_ss_readdata    <= '0;
            end
            if (rsvd || tmo) begin
                o_ss_ack      <= 1'b1;
                o_ss_error    <= 1'b1;
                o_ss_readdata <= SS_ERR_DATA;
            end
            if (accept || tmo) begin
                o_avmm_read  <= 1'b0;
                o_avmm_write <= 1'b0;
            end
            if (accept && is_wr_q) begin
                o_ss_ack <= 1'b1;
            end
            if (rd_done) begin
                o_ss_readdata <= i_avmm_readdata;
                o_ss_ack      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcie_ss_ctrl_bridge.sv
// Directed, table-driven bench for pcie_ss_ctrl_bridge.
// Timeout sequence runs only with PCIE_SS_CTRL_TIMEOUT_EN defined.
module tb_pcie_ss_ctrl_bridge;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   ss_rdata;
    logic          ss_ack, ss_err;
    logic [AW-1:0] av_addr;
    logic          av_rd, av_wr;
    logic [31:0]   av_wdata;
    logic [3:0]    av_be;
    logic          waitreq, rdv;
    logic [31:0]   av_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pcie_ss_ctrl_bridge #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_ss_ctrl_cmd        (cmd),
        .i_ss_ctrl_addr       (addr),
        .i_ss_ctrl_writedata  (wdata),
        .o_ss_readdata        (ss_rdata),
        .o_ss_ack             (ss_ack),
        .o_ss_error           (ss_err),
        .o_avmm_address       (av_addr),
        .o_avmm_read          (av_rd),
        .o_avmm_write         (av_wr),
        .o_avmm_writedata     (av_wdata),
        .o_avmm_byteenable    (av_be),
        .i_avmm_waitrequest   (waitreq),
        .i_avmm_readdatavalid (rdv),
        .i_avmm_readdata      (av_rdata)
    );

    typedef struct {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int            wait_n;
        int            rd_lat;
        logic [31:0]   rdata;
        int            ack_cyc;
        logic          exp_err;
        logic [31:0]   exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic          rd, wr, inwin;
        logic [AW-1:0] a0;
        rd       = (v.cmd == 2'b01);
        wr       = (v.cmd == 2'b10);
        a0       = v.addr;
        cmd      = v.cmd;
        addr     = v.addr;
        wdata    = v.wdata;
        waitreq  = 1'b1;
        rdv      = 1'b0;
        for (int t = 1; t <= v.ack_cyc; t++) begin
            tick();
            inwin = (rd || wr) && (t <= v.wait_n + 1);
            chk($sformatf("v%0d c%0d rd", idx, t), 32'(av_rd), 32'(rd && inwin));
            chk($sformatf("v%0d c%0d wr", idx, t), 32'(av_wr), 32'(wr && inwin));
            chk($sformatf("v%0d c%0d ack", idx, t), 32'(ss_ack),
                32'(t == v.ack_cyc));
            if (inwin)
                chk($sformatf("v%0d c%0d addr", idx, t), 32'(av_addr), 32'(a0));
            if (wr && inwin)
                chk($sformatf("v%0d c%0d wdata", idx, t), av_wdata, v.wdata);
            if (t == v.ack_cyc) begin
                chk($sformatf("v%0d err", idx), 32'(ss_err), 32'(v.exp_err));
                chk($sformatf("v%0d rdata", idx), ss_rdata, v.exp_rdata);
            end
            addr     = ~a0;
            wdata    = ~v.wdata;
            waitreq  = (t <= v.wait_n);
            rdv      = rd && (t == v.wait_n + 1 + v.rd_lat);
            av_rdata = rdv ? v.rdata : 32'h5A5A_C3C3;
        end
        rdv     = 1'b0;
        waitreq = 1'b0;
        cmd     = 2'b00;
        tick();
        chk($sformatf("v%0d ack held", idx), 32'(ss_ack), 32'd1);
        chk($sformatf("v%0d rdata held", idx), ss_rdata, v.exp_rdata);
        tick();
    endtask

    initial begin
        int n;
        vecs[0] = '{2'b10, 20'h00104, 32'hA5A5_0001, 0, 0, 32'h0, 2, 1'b0, 32'h0};
        vecs[1] = '{2'b01, 20'h00200, 32'h0, 3, 5, 32'h1234_5678, 10, 1'b0, 32'h1234_5678};
        vecs[2] = '{2'b11, 20'h00300, 32'h0, 0, 0, 32'h0, 1, 1'b1, 32'hFFFF_FFFF};
        vecs[3] = '{2'b01, 20'h00010, 32'h0, 0, 1, 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{2'b10, 20'h000FC, 32'h0000_0000, 2, 0, 32'h0, 4, 1'b0, 32'h0};
        vecs[5] = '{2'b01, 20'hFFFFC, 32'h0, 1, 2, 32'h0000_0001, 5, 1'b0, 32'h0000_0001};

        rst_n    = 1'b0;
        cmd      = 2'b00;
        addr     = '0;
        wdata    = '0;
        waitreq  = 1'b0;
        rdv      = 1'b0;
        av_rdata = '0;
        tick();
        tick();
        chk("rst rdata", ss_rdata, 32'h0);
        chk("rst ack", 32'(ss_ack), 32'd0);
        chk("rst err", 32'(ss_err), 32'd0);
        chk("rst addr", 32'(av_addr), 32'd0);
        chk("rst rd", 32'(av_rd), 32'd0);
        chk("rst wr", 32'(av_wr), 32'd0);
        chk("rst wdata", av_wdata, 32'h0);
        chk("rst be", 32'(av_be), 32'hF);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Held read command issues exactly one access
        cmd      = 2'b01;
        addr     = 20'h00444;
        waitreq  = 1'b0;
        rdv      = 1'b1;
        av_rdata = 32'h0BAD_F00D;
        n = 0;
        for (int t = 1; t <= 55; t++) begin
            tick();
            if (av_rd) n++;
        end
        chk("held rd count", 32'(n), 32'd1);
        chk("held ack", 32'(ss_ack), 32'd1);
        chk("held rdata", ss_rdata, 32'h0BAD_F00D);
        cmd = 2'b00;
        tick();
        cmd = 2'b01;
        tick();
        chk("rearm rd", 32'(av_rd), 32'd1);
        tick();
        tick();
        chk("rearm ack", 32'(ss_ack), 32'd1);
        cmd = 2'b00;
        rdv = 1'b0;
        tick();
        tick();

        // Cmd dropped mid-write does not abort the access
        cmd     = 2'b10;
        addr    = 20'h00500;
        wdata   = 32'hCAFE_0005;
        waitreq = 1'b1;
        n = 0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            if (av_wr) n++;
            cmd     = 2'b00;
            waitreq = (t <= 3);
        end
        chk("drop wr count", 32'(n), 32'd4);
        chk("drop ack", 32'(ss_ack), 32'd1);
        chk("drop err", 32'(ss_err), 32'd0);
        tick();
        cmd = 2'b10;
        tick();
        chk("drop relaunch", 32'(av_wr), 32'd1);
        chk("drop relaunch ack clr", 32'(ss_ack), 32'd0);
        cmd = 2'b00;
        tick();
        chk("drop relaunch ack", 32'(ss_ack), 32'd1);
        tick();

        // Async reset drops a pending request immediately
        cmd     = 2'b01;
        addr    = 20'h00600;
        waitreq = 1'b1;
        tick();
        chk("issue rd before rst", 32'(av_rd), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst drops rd", 32'(av_rd), 32'd0);
        chk("rst clears addr", 32'(av_addr), 32'd0);
        cmd   = 2'b00;
        #1 rst_n = 1'b1;
        tick();

        // Reset while waiting for read data; late data is ignored
        cmd     = 2'b01;
        addr    = 20'h00700;
        waitreq = 1'b0;
        tick();
        tick();
        chk("wait_rd no strobe", 32'(av_rd), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("wait_rd rst addr", 32'(av_addr), 32'd0);
        chk("wait_rd rst ack", 32'(ss_ack), 32'd0);
        cmd = 2'b00;
        #1 rst_n = 1'b1;
        tick();
        rdv      = 1'b1;
        av_rdata = 32'h7777_7777;
        tick();
        rdv = 1'b0;
        tick();
        chk("late rdv ack", 32'(ss_ack), 32'd0);
        chk("late rdv rdata", ss_rdata, 32'h0);

`ifdef PCIE_SS_CTRL_TIMEOUT_EN
        cmd     = 2'b01;
        addr    = 20'h00800;
        waitreq = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            tick();
            chk($sformatf("tmo c%0d rd", t), 32'(av_rd), 32'(t <= 16));
            chk($sformatf("tmo c%0d ack", t), 32'(ss_ack), 32'(t == 17));
        end
        chk("tmo err", 32'(ss_err), 32'd1);
        chk("tmo rdata", ss_rdata, 32'hFFFF_FFFF);
        cmd     = 2'b00;
        waitreq = 1'b0;
        tick();
        tick();
        run_vec(vecs[0], 10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
